// File: rtl/lcd_responder.sv
// lcd_responder: HD44780-style character LCD bus responder backed by a 32-entry display buffer.
// Optional feature macro: LCD_RESPONDER_BUSY_EN adds the busy-time counter and BUSY state;
// without it, accepted writes complete at once and busy_o only covers the clear/reset FILL.
module lcd_responder #(
  parameter int unsigned BUSY_CYCLES  = 2000,
  parameter int unsigned CLEAR_CYCLES = 82000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       lcd_en_i,
  input  logic       lcd_rs_i,
  input  logic       lcd_rw_i,
  input  logic [7:0] lcd_data_i,
  output logic [7:0] lcd_data_o,
  output logic       lcd_data_oe_o,
  input  logic [4:0] disp_rd_addr_i,
  output logic [7:0] disp_rd_data_o,
  output logic       busy_o,
  output logic [4:0] cursor_o,
  output logic       disp_on_o,
  output logic       ovr_o
);

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 32;
  localparam logic [DW-1:0] FILL_CHAR = 8'h20;

  // FILL needs 32 cycles inside the clear busy window, so the clear time must cover it
  if (BUSY_CYCLES < 1 || CLEAR_CYCLES < 33) begin : g_param_check
    $error("lcd_responder: BUSY_CYCLES must be >= 1 and CLEAR_CYCLES >= 33");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   fill_idx_q;
  logic [AW-1:0]   ac_q;
  logic            id_q;
  logic [DW-1:0]   mem_q [DEPTH];

  logic            en_q, en_d;
  logic            rs_q, rw_q;
  logic [DW-1:0]   data_q;
  logic            acc_rs, acc_rw;
  logic [DW-1:0]   acc_data;

  logic            fall_c, wr_fall_c, rd_fall_c, wr_ok_c, is_clear_c;

`ifdef LCD_RESPONDER_BUSY_EN
  localparam int unsigned MAX_CYCLES = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
  logic [CW-1:0]   cnt_q;
  logic            post_reset_q;
  logic            is_home_c;
  assign is_home_c = ~acc_rs & (acc_data[7:1] == 7'h01);
`endif

  // Step the address counter by one in the requested direction, wrapping modulo 32
  function automatic logic [AW-1:0] step_ac(input logic [AW-1:0] a, input logic up);
    return up ? a + AW'(1) : a - AW'(1);
  endfunction

  // Bus access decode: one access per registered EN falling edge
  assign fall_c     = en_d & ~en_q;
  assign wr_fall_c  = fall_c & ~acc_rw;
  assign rd_fall_c  = fall_c & acc_rw;
  assign wr_ok_c    = wr_fall_c & ~busy_o;
  assign is_clear_c = ~acc_rs & (acc_data == 8'h01);

  assign disp_rd_data_o = mem_q[disp_rd_addr_i];
  assign cursor_o       = ac_q;

  // Input capture, plus the access fields as they stood while EN was last high
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q     <= 1'b0;
      en_d     <= 1'b0;
      rs_q     <= 1'b0;
      rw_q     <= 1'b0;
      data_q   <= '0;
      acc_rs   <= 1'b0;
      acc_rw   <= 1'b0;
      acc_data <= '0;
    end else begin
      en_q   <= lcd_en_i;
      en_d   <= en_q;
      rs_q   <= lcd_rs_i;
      rw_q   <= lcd_rw_i;
      data_q <= lcd_data_i;
      if (en_q) begin
        acc_rs   <= rs_q;
        acc_rw   <= rw_q;
        acc_data <= data_q;
      end
    end
  end

  // Read-back drive: status/AC or buffer byte while a read strobe is held
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lcd_data_oe_o <= 1'b0;
      lcd_data_o    <= '0;
    end else begin
      lcd_data_oe_o <= en_q & rw_q;
      if (en_q && rw_q) begin
        lcd_data_o <= rs_q ? mem_q[ac_q] : {busy_o, 2'b00, ac_q};
      end else begin
        lcd_data_o <= '0;
      end
    end
  end

  // Display buffer: FILL sweep has priority, otherwise accepted data writes
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == S_FILL) begin
        mem_q[fill_idx_q] <= FILL_CHAR;
      end else if (wr_ok_c && acc_rs) begin
        mem_q[ac_q] <= acc_data;
      end
    end
  end

  // Controller FSM with instruction decode, address counter and status flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_FILL;
      fill_idx_q <= '0;
      ac_q       <= '0;
      id_q       <= 1'b1;
      disp_on_o  <= 1'b0;
      ovr_o      <= 1'b0;
      busy_o     <= 1'b1;
`ifdef LCD_RESPONDER_BUSY_EN
      cnt_q        <= '0;
      post_reset_q <= 1'b1;
`endif
    end else begin
      if (wr_fall_c && busy_o) begin
        ovr_o <= 1'b1;
      end
      if (rd_fall_c && acc_rs) begin
        ac_q <= step_ac(ac_q, id_q);
      end
      if (wr_ok_c && acc_rs) begin
        ac_q <= step_ac(ac_q, id_q);
      end
      if (wr_ok_c && !acc_rs) begin
        casez (acc_data)
          8'b1???????: ac_q <= acc_data[AW-1:0];
          8'b01??????, 8'b001?????: begin end
          8'b0001????: ac_q <= step_ac(ac_q, acc_data[2]);
          8'b00001???: disp_on_o <= acc_data[2];
          8'b000001??: id_q <= acc_data[1];
          8'b0000001?: ac_q <= '0;
          default: begin end
        endcase
      end

      case (state_q)
        S_FILL: begin
          fill_idx_q <= fill_idx_q + AW'(1);
          if (fill_idx_q == AW'(DEPTH - 1)) begin
            ac_q <= '0;
            id_q <= 1'b1;
`ifdef LCD_RESPONDER_BUSY_EN
            // The reset fill ends straight in IDLE; a clear fill owes its remaining busy time
            post_reset_q <= 1'b0;
            if (post_reset_q) begin
              state_q <= S_IDLE;
              busy_o  <= 1'b0;
            end else begin
              state_q <= S_BUSY;
              cnt_q   <= CW'(CLEAR_CYCLES - 33);
            end
`else
            state_q <= S_IDLE;
            busy_o  <= 1'b0;
`endif
          end
        end
`ifdef LCD_RESPONDER_BUSY_EN
        S_BUSY: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            busy_o  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
`endif
        default: begin
          if (wr_ok_c) begin
            if (is_clear_c) begin
              state_q    <= S_FILL;
              fill_idx_q <= '0;
              busy_o     <= 1'b1;
            end else begin
`ifdef LCD_RESPONDER_BUSY_EN
              state_q <= S_BUSY;
              busy_o  <= 1'b1;
              cnt_q   <= is_home_c ? CW'(CLEAR_CYCLES - 1) : CW'(BUSY_CYCLES - 1);
`endif
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_responder.sv
// tb_lcd_responder: directed self-checking bench for lcd_responder (either build of LCD_RESPONDER_BUSY_EN).
module tb_lcd_responder;

  localparam int unsigned TB_BUSY  = 2000;
  localparam int unsigned TB_CLEAR = 1640;
`ifdef LCD_RESPONDER_BUSY_EN
  localparam bit BUSY_EN = 1'b1;
`else
  localparam bit BUSY_EN = 1'b0;
`endif
  localparam int EXP_WR_BUSY  = BUSY_EN ? int'(TB_BUSY) : 0;
  localparam int EXP_CLR_BUSY = BUSY_EN ? int'(TB_CLEAR) : 32;

  logic       clk, rst;
  logic       lcd_en, lcd_rs, lcd_rw;
  logic [7:0] lcd_data_in, lcd_data_out;
  logic       lcd_data_oe;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy, disp_on, ovr;
  logic [4:0] cursor;

  int n_tests = 0;
  int n_fail  = 0;

  lcd_responder #(.BUSY_CYCLES(TB_BUSY), .CLEAR_CYCLES(TB_CLEAR)) dut (
    .clk_i(clk), .rst_i(rst),
    .lcd_en_i(lcd_en), .lcd_rs_i(lcd_rs), .lcd_rw_i(lcd_rw),
    .lcd_data_i(lcd_data_in), .lcd_data_o(lcd_data_out), .lcd_data_oe_o(lcd_data_oe),
    .disp_rd_addr_i(rd_addr), .disp_rd_data_o(rd_data),
    .busy_o(busy), .cursor_o(cursor), .disp_on_o(disp_on), .ovr_o(ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One strobed write; its effect is visible when the task returns
  task automatic bus_write(input logic rs, input logic [7:0] d);
    lcd_en = 1'b1; lcd_rs = rs; lcd_rw = 1'b0; lcd_data_in = d;
    tick_n(2);
    lcd_en = 1'b0;
    tick_n(2);
  endtask

  // Count cycles until busy_o drops, bounded
  task automatic measure_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < int'(TB_CLEAR) + 200) begin
      tick_n(1);
      n++;
    end
  endtask

  task automatic peek(input logic [4:0] a, output logic [7:0] d);
    rd_addr = a;
    #1;
    d = rd_data;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick_n(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    lcd_en = 0; lcd_rs = 0; lcd_rw = 0; lcd_data_in = 0; rd_addr = 0;
    rst = 1'b1;
    tick_n(2);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy); end
    n_tests++; if (cursor !== 5'd0) begin n_fail++; $display("FAIL reset_cursor: got %0d want 0", cursor); end
    n_tests++; if (disp_on !== 1'b0 || ovr !== 1'b0) begin n_fail++; $display("FAIL reset_flags: disp_on %b ovr %b want 0 0", disp_on, ovr); end
    n_tests++; if (lcd_data_oe !== 1'b0 || lcd_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_bus: oe %b data %h want 0 00", lcd_data_oe, lcd_data_out); end
    rst = 1'b0;
    measure_busy(n);
    n_tests++; if (n !== 32) begin n_fail++; $display("FAIL reset_fill_len: got %0d want 32", n); end
  endtask

  task automatic test_write_basic();
    int n;
    logic [7:0] d;
    bus_write(1'b0, 8'h80);
    measure_busy(n);
    n_tests++; if (n !== EXP_WR_BUSY) begin n_fail++; $display("FAIL instr_busy_len: got %0d want %0d", n, EXP_WR_BUSY); end
    bus_write(1'b1, 8'h41);
    peek(5'd0, d);
    n_tests++; if (d !== 8'h41) begin n_fail++; $display("FAIL data_write_buf0: got %h want 41", d); end
    n_tests++; if (cursor !== 5'd1) begin n_fail++; $display("FAIL data_write_cursor: got %0d want 1", cursor); end
    n_tests++; if (busy !== BUSY_EN) begin n_fail++; $display("FAIL data_write_busy: got %b want %b", busy, BUSY_EN); end
    measure_busy(n);
    n_tests++; if (n !== EXP_WR_BUSY) begin n_fail++; $display("FAIL data_busy_len: got %0d want %0d", n, EXP_WR_BUSY); end
  endtask

  task automatic test_entry_decrement();
    int n;
    logic [7:0] d;
    bus_write(1'b0, 8'h04); measure_busy(n);
    bus_write(1'b0, 8'h80); measure_busy(n);
    bus_write(1'b1, 8'h5A);
    peek(5'd0, d);
    n_tests++; if (d !== 8'h5A) begin n_fail++; $display("FAIL dec_buf0: got %h want 5a", d); end
    n_tests++; if (cursor !== 5'd31) begin n_fail++; $display("FAIL dec_cursor_wrap: got %0d want 31", cursor); end
    measure_busy(n);
  endtask

  task automatic test_overrun();
    int n;
    logic [7:0] d;
    n_tests++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_pre: got %b want 0", ovr); end
    bus_write(1'b1, 8'h11);
    tick_n(6);
    bus_write(1'b1, 8'h22);
    peek(5'd31, d);
    n_tests++; if (d !== 8'h11) begin n_fail++; $display("FAIL ovr_first_write: got %h want 11", d); end
    peek(5'd30, d);
    n_tests++; if (d !== (BUSY_EN ? 8'h20 : 8'h22)) begin n_fail++; $display("FAIL ovr_second_write: got %h want %h", d, BUSY_EN ? 8'h20 : 8'h22); end
    n_tests++; if (ovr !== BUSY_EN) begin n_fail++; $display("FAIL ovr_flag: got %b want %b", ovr, BUSY_EN); end
    n_tests++; if (cursor !== (BUSY_EN ? 5'd30 : 5'd29)) begin n_fail++; $display("FAIL ovr_cursor: got %0d want %0d", cursor, BUSY_EN ? 30 : 29); end
    measure_busy(n);
    n_tests++; if (n !== (BUSY_EN ? int'(TB_BUSY) - 10 : 0)) begin n_fail++; $display("FAIL ovr_busy_rest: got %0d want %0d", n, BUSY_EN ? int'(TB_BUSY) - 10 : 0); end
  endtask

  task automatic test_busy_read();
    int n;
    bus_write(1'b0, 8'h85);
    lcd_en = 1'b1; lcd_rs = 1'b0; lcd_rw = 1'b1;
    tick_n(2);
    n_tests++; if (lcd_data_oe !== 1'b1) begin n_fail++; $display("FAIL bf_read_oe: got %b want 1", lcd_data_oe); end
    n_tests++; if (lcd_data_out !== (BUSY_EN ? 8'h85 : 8'h05)) begin n_fail++; $display("FAIL bf_read_busy: got %h want %h", lcd_data_out, BUSY_EN ? 8'h85 : 8'h05); end
    lcd_en = 1'b0;
    tick_n(2);
    n_tests++; if (lcd_data_oe !== 1'b0 || lcd_data_out !== 8'h00) begin n_fail++; $display("FAIL bf_read_release: oe %b data %h want 0 00", lcd_data_oe, lcd_data_out); end
    n_tests++; if (cursor !== 5'd5) begin n_fail++; $display("FAIL bf_read_no_step: got %0d want 5", cursor); end
    measure_busy(n);
    n_tests++; if (n !== (BUSY_EN ? int'(TB_BUSY) - 4 : 0)) begin n_fail++; $display("FAIL bf_busy_rest: got %0d want %0d", n, BUSY_EN ? int'(TB_BUSY) - 4 : 0); end
    lcd_en = 1'b1;
    tick_n(2);
    n_tests++; if (lcd_data_out !== 8'h05) begin n_fail++; $display("FAIL bf_read_idle: got %h want 05", lcd_data_out); end
    lcd_en = 1'b0;
    tick_n(2);
    // data read at AC=5 with ID=0 returns the byte and steps AC down
    lcd_en = 1'b1; lcd_rs = 1'b1;
    tick_n(2);
    n_tests++; if (lcd_data_out !== 8'h20) begin n_fail++; $display("FAIL data_read_val: got %h want 20", lcd_data_out); end
    lcd_en = 1'b0;
    tick_n(2);
    n_tests++; if (cursor !== 5'd4) begin n_fail++; $display("FAIL data_read_step: got %0d want 4", cursor); end
    lcd_rw = 1'b0;
  endtask

  task automatic test_cursor_wrap();
    int n;
    logic [7:0] d;
    bus_write(1'b0, 8'h9F); measure_busy(n);
    bus_write(1'b0, 8'h14);
    n_tests++; if (cursor !== 5'd0) begin n_fail++; $display("FAIL shift_right_wrap: got %0d want 0", cursor); end
    measure_busy(n);
    n_tests++; if (n !== EXP_WR_BUSY) begin n_fail++; $display("FAIL shift_busy_len: got %0d want %0d", n, EXP_WR_BUSY); end
    bus_write(1'b0, 8'h10);
    n_tests++; if (cursor !== 5'd31) begin n_fail++; $display("FAIL shift_left_wrap: got %0d want 31", cursor); end
    measure_busy(n);
    bus_write(1'b0, 8'h06); measure_busy(n);
    bus_write(1'b1, 8'hC3);
    peek(5'd31, d);
    n_tests++; if (d !== 8'hC3 || cursor !== 5'd0) begin n_fail++; $display("FAIL inc_wrap: buf31 %h cursor %0d want c3 0", d, cursor); end
    measure_busy(n);
  endtask

  task automatic test_clear();
    int n;
    int bad;
    logic [7:0] d;
    bus_write(1'b0, 8'h82); measure_busy(n);
    bus_write(1'b1, 8'h33); measure_busy(n);
    bus_write(1'b0, 8'h94); measure_busy(n);
    bus_write(1'b1, 8'h44); measure_busy(n);
    bus_write(1'b0, 8'h0C); measure_busy(n);
    n_tests++; if (disp_on !== 1'b1) begin n_fail++; $display("FAIL disp_on_set: got %b want 1", disp_on); end
    bus_write(1'b0, 8'h04); measure_busy(n);
    bus_write(1'b0, 8'h01);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clear_busy_start: got %b want 1", busy); end
    tick_n(3);
    peek(5'd2, d);
    n_tests++; if (d !== 8'h20) begin n_fail++; $display("FAIL fill_done_entry2: got %h want 20", d); end
    peek(5'd20, d);
    n_tests++; if (d !== 8'h44) begin n_fail++; $display("FAIL fill_pending_entry20: got %h want 44", d); end
    measure_busy(n);
    n_tests++; if (n !== EXP_CLR_BUSY - 3) begin n_fail++; $display("FAIL clear_busy_len: got %0d want %0d", n + 3, EXP_CLR_BUSY); end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      peek(5'(i), d);
      if (d !== 8'h20) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL clear_all_0x20: %0d entries differ, want 0", bad); end
    n_tests++; if (cursor !== 5'd0) begin n_fail++; $display("FAIL clear_cursor: got %0d want 0", cursor); end
    bus_write(1'b1, 8'h55);
    n_tests++; if (cursor !== 5'd1) begin n_fail++; $display("FAIL clear_id_restored: got %0d want 1", cursor); end
    measure_busy(n);
  endtask

  task automatic test_reset_mid_clear();
    int n;
    logic [7:0] d;
    bus_write(1'b0, 8'h8F); measure_busy(n);
    bus_write(1'b1, 8'h77); measure_busy(n);
    bus_write(1'b0, 8'h01);
    tick_n(10);
    peek(5'd15, d);
    n_tests++; if (d !== 8'h77) begin n_fail++; $display("FAIL midclear_entry15: got %h want 77", d); end
    do_reset();
    n_tests++; if (busy !== 1'b1 || disp_on !== 1'b0 || ovr !== 1'b0 || cursor !== 5'd0) begin
      n_fail++; $display("FAIL midclear_reset_state: busy %b disp_on %b ovr %b cursor %0d want 1 0 0 0", busy, disp_on, ovr, cursor);
    end
    measure_busy(n);
    n_tests++; if (n !== 32) begin n_fail++; $display("FAIL midclear_refill_len: got %0d want 32", n); end
    peek(5'd15, d);
    n_tests++; if (d !== 8'h20) begin n_fail++; $display("FAIL midclear_refill_entry15: got %h want 20", d); end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_entry_decrement();
    test_overrun();
    test_busy_read();
    test_cursor_wrap();
    test_clear();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
